// File: rtl/dcache_mem_responder.sv
// Responder for the load/store buffer: serializes byte/half/word accesses onto a
// byte-wide little-endian memory bus and returns zero-extended read data or a write ack.
module dcache_mem_responder #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic                  clockIn,
    input  logic                  resetIn,
    input  logic                  clearIn,
    input  logic [1:0]            accessType,
    input  logic                  readWriteIn,
    input  logic [ADDR_WIDTH-1:0] dataAddr,
    input  logic [31:0]           dataIn,
    output logic                  dataValid,
    output logic [31:0]           dataOut,
    output logic                  dataWriteSuc,
    input  logic [7:0]            memIn,
    output logic [7:0]            memOut,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memWrite,
    input  logic                  ioBufferFull
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_TAIL,
        WR,
        WR_STALL,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [31:0]             wr_data;
    logic [31:0]             assembly;
    logic [1:0]              byte_cnt;
    logic [1:0]              last_byte;
    logic [1:0]              cap_idx;
    logic                    is_read;
    logic                    is_io;
    logic                    accept;
    logic                    stall;

    // A read sampled together with a flush is dropped; writes are always taken.
    assign accept  = (state == IDLE || state == DONE) && (accessType != 2'b00)
                     && !(readWriteIn && clearIn);
    assign stall   = is_io && ioBufferFull;
    // memIn lags memAddr by one cycle, so RD_ADDR captures the previous byte.
    assign cap_idx = (state == RD_TAIL) ? byte_cnt : byte_cnt - 2'd1;
    assign dataOut = assembly;

    always_comb begin
        state_next   = state;
        memAddr      = '0;
        memOut       = 8'h00;
        memWrite     = 1'b0;
        dataValid    = 1'b0;
        dataWriteSuc = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = readWriteIn ? RD_ADDR : WR;
            end
            RD_ADDR: begin
                memAddr = base_addr + ADDR_WIDTH'(byte_cnt);
                if (clearIn)                    state_next = IDLE;
                else if (byte_cnt == last_byte) state_next = RD_TAIL;
            end
            RD_TAIL: begin
                state_next = clearIn ? IDLE : DONE;
            end
            WR, WR_STALL: begin
                if (stall) begin
                    state_next = WR_STALL;
                end else begin
                    memWrite   = 1'b1;
                    memAddr    = base_addr + ADDR_WIDTH'(byte_cnt);
                    memOut     = wr_data[{byte_cnt, 3'b000} +: 8];
                    state_next = (byte_cnt == last_byte) ? DONE : WR;
                end
            end
            DONE: begin
                dataValid    = is_read && !clearIn;
                dataWriteSuc = !is_read;
                if (accept) state_next = readWriteIn ? RD_ADDR : WR;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state     <= IDLE;
            base_addr <= '0;
            wr_data   <= '0;
            assembly  <= '0;
            byte_cnt  <= 2'd0;
            last_byte <= 2'd0;
            is_read   <= 1'b0;
            is_io     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                base_addr <= dataAddr;
                wr_data   <= dataIn;
                assembly  <= '0;
                byte_cnt  <= 2'd0;
                last_byte <= (accessType == 2'b01) ? 2'd0 :
                             (accessType == 2'b10) ? 2'd1 : 2'd3;
                is_read   <= readWriteIn;
                is_io     <= (dataAddr[17:16] == IO_ADDR_HI);
            end else begin
                case (state)
                    RD_ADDR: begin
                        if (byte_cnt != 2'd0) assembly[{cap_idx, 3'b000} +: 8] <= memIn;
                        if (byte_cnt != last_byte) byte_cnt <= byte_cnt + 2'd1;
                    end
                    RD_TAIL: assembly[{cap_idx, 3'b000} +: 8] <= memIn;
                    WR, WR_STALL: begin
                        if (!stall && byte_cnt != last_byte) byte_cnt <= byte_cnt + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
